// File: rtl/wb_unit_if.sv
// Execute-to-writeback handshake: one retiring instruction per valid/ready transfer.
interface wb_unit_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic            wb_en;
  logic            is_load;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [1:0]      addr_lo;
  logic [XLEN-1:0] result;

  modport master (
    output valid, wb_en, is_load, rd, funct3, addr_lo, result,
    input  ready
  );

  modport slave (
    input  valid, wb_en, is_load, rd, funct3, addr_lo, result,
    output ready
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback stage: retires execute results, completes loads one cycle after acceptance,
// drives the register-file write port and keeps the 64-bit retired-instruction counter.
module wb_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_unit_if.slave        ex,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_d,
  output logic            reg_wr,
  output logic            load_busy,
  output logic [4:0]      load_rd,
  output logic [63:0]     instret
);

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_t;

  state_t          state;

  logic [4:0]      cap_rd;
  logic [2:0]      cap_funct3;
  logic [1:0]      cap_addr_lo;
  logic            cap_wb_en;

  logic            accept;
  logic            retire;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic [XLEN-1:0] load_data;
  logic [63:0]     instret_nxt;

  // Ready is a pure function of state and reset, so execute never sees a loop through valid.
  assign ex.ready = rst_n && (state == S_IDLE);
  assign accept   = ex.valid && ex.ready;

  // A non-load retires on acceptance, a load on completion; the states exclude both at once.
  assign retire      = (accept && !ex.is_load) || (state == S_LOAD);
  assign instret_nxt = instret + 64'(retire);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    lane_byte = mem_rdata[7:0];
    unique case (cap_addr_lo)
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
    endcase

    lane_half = cap_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    case (cap_funct3)
      3'b000:  load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, lane_byte};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, lane_half};
      default: load_data = mem_rdata;
    endcase
  end

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd          <= 5'd0;
      rd_d        <= '0;
      reg_wr      <= 1'b0;
      load_busy   <= 1'b0;
      load_rd     <= 5'd0;
      instret     <= 64'd0;
      cap_rd      <= 5'd0;
      cap_funct3  <= 3'd0;
      cap_addr_lo <= 2'd0;
      cap_wb_en   <= 1'b0;
    end else begin
      instret <= instret_nxt;

      unique case (state)
        S_IDLE: begin
          reg_wr <= 1'b0;
          if (accept) begin
            if (ex.is_load) begin
              cap_rd      <= ex.rd;
              cap_funct3  <= ex.funct3;
              cap_addr_lo <= ex.addr_lo;
              cap_wb_en   <= ex.wb_en;
              load_busy   <= 1'b1;
              load_rd     <= ex.rd;
              state       <= S_LOAD;
            end else begin
              rd     <= ex.rd;
              rd_d   <= ex.result;
              reg_wr <= ex.wb_en && (ex.rd != 5'd0);
            end
          end
        end

        // Execute inputs are ignored here; only the memory word matters this cycle.
        S_LOAD: begin
          rd        <= cap_rd;
          rd_d      <= load_data;
          reg_wr    <= cap_wb_en && (cap_rd != 5'd0);
          load_busy <= 1'b0;
          load_rd   <= 5'd0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: stimulus pushes expected retirements, a monitor pops
// and compares them each time the retired-instruction count moves.
module tb_wb_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic [31:0] rd_d;
  logic        reg_wr;
  logic        load_busy;
  logic [4:0]  load_rd;
  logic [63:0] instret;

  wb_unit_if #(.XLEN(32)) ex ();

  wb_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex        (ex),
    .mem_rdata (mem_rdata),
    .rd        (rd),
    .rd_d      (rd_d),
    .reg_wr    (reg_wr),
    .load_busy (load_busy),
    .load_rd   (load_rd),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] m_instret = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load result, computed from the width/sign rules with plain arithmetic.
  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * int'(lo))) & 32'hFF;
    h = lo[1] ? (word >> 16) : (word & 32'hFFFF);
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic expect_retire(input logic wr, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    m_instret = m_instret + 64'd1;
    e.wr  = wr;
    e.rd  = r;
    e.d   = d;
    e.cnt = m_instret;
    sb.push_back(e);
  endtask

  task automatic scramble_fields();
    ex.wb_en   = 1'($urandom);
    ex.is_load = 1'($urandom);
    ex.rd      = 5'($urandom);
    ex.funct3  = 3'($urandom);
    ex.addr_lo = 2'($urandom);
    ex.result  = $urandom;
  endtask

  task automatic go_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ex.valid = 1'b0;
      scramble_fields();
      mem_rdata = $urandom;
    end
  endtask

  task automatic send_alu(input logic [4:0] r, input logic [31:0] res, input logic wb);
    @(negedge clk);
    ex.valid   = 1'b1;
    ex.is_load = 1'b0;
    ex.wb_en   = wb;
    ex.rd      = r;
    ex.funct3  = 3'($urandom);
    ex.addr_lo = 2'($urandom);
    ex.result  = res;
    mem_rdata  = $urandom;
    #1;
    check("alu_ex_ready", 64'(ex.ready), 64'd1);
    expect_retire(wb && (r != 5'd0), r, res);
  endtask

  task automatic send_load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] lo,
                           input logic wb, input logic [31:0] word);
    @(negedge clk);
    ex.valid   = 1'b1;
    ex.is_load = 1'b1;
    ex.wb_en   = wb;
    ex.rd      = r;
    ex.funct3  = f3;
    ex.addr_lo = lo;
    ex.result  = $urandom;
    #1;
    check("load_ex_ready", 64'(ex.ready), 64'd1);
    // Wait cycle: present a garbage instruction that must be ignored, plus the memory word.
    @(negedge clk);
    ex.valid  = 1'b1;
    scramble_fields();
    mem_rdata = word;
    #1;
    check("load_wait_ex_ready", 64'(ex.ready), 64'd0);
    check("load_wait_busy", 64'(load_busy), 64'd1);
    check("load_wait_load_rd", 64'(load_rd), 64'(r));
    expect_retire(wb && (r != 5'd0), r, load_value(word, f3, lo));
    @(negedge clk);
    ex.valid  = 1'b0;
    mem_rdata = $urandom;
    #1;
    check("load_after_ex_ready", 64'(ex.ready), 64'd1);
    check("load_after_busy", 64'(load_busy), 64'd0);
    check("load_after_load_rd", 64'(load_rd), 64'd0);
  endtask

  // Monitor: every change of instret is one retirement and must match the queue head.
  initial begin : monitor
    logic [63:0] prev;
    exp_t        e;
    prev = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = instret;
      end else if (instret != prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_retire: instret %h, nothing expected (t=%0t)", instret, $time);
        end else begin
          e = sb.pop_front();
          check("retire_reg_wr", 64'(reg_wr), 64'(e.wr));
          if (e.wr) begin
            check("retire_rd", 64'(rd), 64'(e.rd));
            check("retire_rd_d", 64'(rd_d), 64'(e.d));
          end
          check("retire_instret", instret, e.cnt);
        end
        prev = instret;
      end else if (reg_wr) begin
        check("spurious_reg_wr", 64'(reg_wr), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] LDW = 32'h80F07F81;

  initial begin : stimulus
    int wait_cycles;
    rst_n     = 1'b0;
    ex.valid  = 1'b1;
    scramble_fields();
    ex.is_load = 1'b0;
    mem_rdata = 32'd0;

    // Reset, with a valid instruction presented that must not transfer.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ex_ready", 64'(ex.ready), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_rd_d", 64'(rd_d), 64'd0);
    check("rst_reg_wr", 64'(reg_wr), 64'd0);
    check("rst_load_busy", 64'(load_busy), 64'd0);
    check("rst_load_rd", 64'(load_rd), 64'd0);
    check("rst_instret", instret, 64'd0);
    ex.valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_ex_ready", 64'(ex.ready), 64'd1);

    go_idle(10);
    #1;
    check("idle_instret", instret, 64'd0);
    check("idle_reg_wr", 64'(reg_wr), 64'd0);

    // Back-to-back ALU stream.
    send_alu(5'd1, 32'h0000_0001, 1'b1);
    send_alu(5'd3, 32'h0000_0002, 1'b1);
    go_idle(1);
    #1;
    check("alu_stream_instret", instret, 64'd2);

    // Every load flavour against one memory word.
    send_load(5'd4,  3'b000, 2'd0, 1'b1, LDW);
    send_load(5'd5,  3'b100, 2'd0, 1'b1, LDW);
    send_load(5'd6,  3'b000, 2'd1, 1'b1, LDW);
    send_load(5'd7,  3'b001, 2'd2, 1'b1, LDW);
    send_load(5'd8,  3'b101, 2'd2, 1'b1, LDW);
    send_load(5'd9,  3'b010, 2'd0, 1'b1, LDW);
    send_load(5'd10, 3'b011, 2'd3, 1'b1, LDW);

    // x0 destination and a store: counted, never written.
    send_alu(5'd0, 32'hDEAD_BEEF, 1'b1);
    send_alu(5'd12, 32'h1234_5678, 1'b0);
    go_idle(1);
    #1;
    check("x0_store_instret", instret, m_instret);

    // Randomized mix.
    for (int i = 0; i < 250; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)
        send_alu(5'($urandom), $urandom, ($urandom_range(0, 3) != 0));
      else if (kind <= 8)
        send_load(5'($urandom), 3'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      else
        go_idle(int'($urandom_range(1, 3)));
    end
    go_idle(2);

    // Reset while a load is outstanding.
    @(negedge clk);
    ex.valid   = 1'b1;
    ex.is_load = 1'b1;
    ex.wb_en   = 1'b1;
    ex.rd      = 5'd5;
    ex.funct3  = 3'b010;
    ex.addr_lo = 2'd0;
    @(negedge clk);
    rst_n     = 1'b0;
    ex.valid  = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    #1;
    check("mid_load_rst_reg_wr", 64'(reg_wr), 64'd0);
    check("mid_load_rst_instret", instret, 64'd0);
    check("mid_load_rst_busy", 64'(load_busy), 64'd0);
    check("mid_load_rst_ex_ready", 64'(ex.ready), 64'd0);
    m_instret = 64'd0;
    rst_n     = 1'b1;
    go_idle(2);
    #1;
    check("mid_load_after_instret", instret, 64'd0);

    // Counter wrap: preload the counter to all ones, then retire one instruction.
    @(negedge clk);
    force dut.instret_nxt = 64'hFFFF_FFFF_FFFF_FFFF;
    begin
      exp_t e;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      e.wr  = 1'b0;
      e.rd  = 5'd0;
      e.d   = 32'd0;
      e.cnt = m_instret;
      sb.push_back(e);
    end
    @(negedge clk);
    release dut.instret_nxt;
    go_idle(1);
    send_alu(5'd7, 32'hCAFE_0007, 1'b1);
    go_idle(1);
    #1;
    check("wrap_instret", instret, 64'd0);

    // Drain the scoreboard within a bounded number of cycles.
    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expected retirements never observed", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
